// File: rtl/round_key_add_stage_pkg.sv
// round_key_add_stage_pkg: shared AES widths and skid buffer state encoding
package round_key_add_stage_pkg;
  localparam int AES_BLOCK = 128;
  typedef enum logic [1:0] {EMPTY, ONE, TWO} skid_state_e;
endpackage

// File: rtl/round_key_add_stage_if.sv
// round_key_add_stage_if: key write port plus input/output valid-ready block streams
interface round_key_add_stage_if #(
  parameter int BLOCK_LENGTH = 128,
  parameter int KEY_SEL_W    = 1,
  parameter int TAG_WIDTH    = 4
);
  logic                    key_wr_en;
  logic [KEY_SEL_W-1:0]    key_wr_sel;
  logic [BLOCK_LENGTH-1:0] key_wr_data;
  logic                    in_valid;
  logic                    in_ready;
  logic [BLOCK_LENGTH-1:0] in_data;
  logic [KEY_SEL_W-1:0]    in_key_sel;
  logic [TAG_WIDTH-1:0]    in_tag;
  logic                    out_valid;
  logic                    out_ready;
  logic [BLOCK_LENGTH-1:0] out_data;
  logic [TAG_WIDTH-1:0]    out_tag;
  modport master (
    output key_wr_en, key_wr_sel, key_wr_data, in_valid, in_data, in_key_sel, in_tag, out_ready,
    input  in_ready, out_valid, out_data, out_tag
  );
  modport slave (
    input  key_wr_en, key_wr_sel, key_wr_data, in_valid, in_data, in_key_sel, in_tag, out_ready,
    output in_ready, out_valid, out_data, out_tag
  );
endinterface

// File: rtl/round_key_add_stage_skid.sv
// round_key_add_stage_skid: generic 2-entry valid/ready skid buffer with registered in_ready
module round_key_add_stage_skid
  import round_key_add_stage_pkg::*;
#(
  parameter int WIDTH = 132
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);
  skid_state_e state_q, state_d;
  logic [WIDTH-1:0] main_q, main_d, skid_q, skid_d;
  logic in_ready_q;
  always_comb begin
    state_d = state_q;
    main_d = main_q;
    skid_d = skid_q;
    case (state_q)
      EMPTY: if (in_valid) begin
        main_d = in_data;
        state_d = ONE;
      end
      ONE: begin
        main_d = in_valid && out_ready ? in_data : main_q;
        skid_d = in_valid && !out_ready ? in_data : skid_q;
        state_d = in_valid && !out_ready ? TWO : !in_valid && out_ready ? EMPTY : ONE;
      end
      TWO: if (out_ready) begin
        main_d = skid_q;
        state_d = ONE;
      end
      default: state_d = EMPTY;
    endcase
  end
  always_ff @(posedge clk) begin
    state_q <= rst ? EMPTY : state_d;
    main_q <= rst ? '0 : main_d;
    skid_q <= rst ? '0 : skid_d;
    in_ready_q <= rst ? 1'b1 : state_d != TWO;
  end
  assign in_ready = in_ready_q;
  assign out_valid = state_q != EMPTY;
  assign out_data = main_q;
endmodule

// File: rtl/round_key_add_stage.sv
// round_key_add_stage: flow-controlled AddRoundKey stage with local key bank, tag passthrough and block counter
module round_key_add_stage
  import round_key_add_stage_pkg::*;
#(
  parameter int BLOCK_LENGTH = AES_BLOCK,
  parameter int NUM_KEYS     = 2,
  parameter int KEY_SEL_W    = 1,
  parameter int TAG_WIDTH    = 4,
  parameter bit ZERO_IDLE    = 1'b1,
  parameter int CNT_WIDTH    = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  round_key_add_stage_if.slave bus,
  output logic [CNT_WIDTH-1:0] blk_count
);
  localparam int W = BLOCK_LENGTH + TAG_WIDTH;
  logic [BLOCK_LENGTH-1:0] key_q [NUM_KEYS];
  logic [BLOCK_LENGTH-1:0] key_d [NUM_KEYS];
  logic [BLOCK_LENGTH-1:0] key_rd;
  logic [KEY_SEL_W-1:0] rd_sel, wr_sel;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [W-1:0] stage_out;
  logic out_valid;
  assign rd_sel = bus.in_key_sel;
  assign wr_sel = bus.key_wr_sel;
  always_comb begin
    key_rd = key_q[0];
    for (int k = 1; k < NUM_KEYS; k++) key_rd = int'(rd_sel) == k ? key_q[k] : key_rd;
    for (int k = 0; k < NUM_KEYS; k++) key_d[k] = bus.key_wr_en && int'(wr_sel) == k ? bus.key_wr_data : key_q[k];
    cnt_d = out_valid && bus.out_ready && cnt_q != '1 ? cnt_q + CNT_WIDTH'(1) : cnt_q;
  end
  always_ff @(posedge clk) begin
    cnt_q <= rst ? '0 : cnt_d;
    for (int k = 0; k < NUM_KEYS; k++) key_q[k] <= rst ? '0 : key_d[k];
  end
  round_key_add_stage_skid #(.WIDTH(W)) u_skid (
    .clk      (clk),
    .rst      (rst),
    .in_valid (bus.in_valid),
    .in_ready (bus.in_ready),
    .in_data  ({bus.in_data ^ key_rd, bus.in_tag}),
    .out_valid(out_valid),
    .out_ready(bus.out_ready),
    .out_data (stage_out)
  );
  assign bus.out_valid = out_valid;
  assign {bus.out_data, bus.out_tag} = ZERO_IDLE && !out_valid ? '0 : stage_out;
  assign blk_count = cnt_q;
endmodule

// File: tb/tb_round_key_add_stage.sv
// tb_round_key_add_stage: directed checks of the AddRoundKey stage
module tb_round_key_add_stage;
  localparam logic [127:0] K = 128'h13111d7fe3944a17f307a78b4d2b30c5;
  localparam logic [127:0] P = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] C = 128'h7ad5fda789ef4e272bca100b3d9ff59f;
  localparam logic [127:0] K2 = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] A = 128'h0000000000000000000000000000000a;
  localparam logic [127:0] B = 128'h000000000000000000000000000000b0;
  localparam logic [127:0] D = 128'hd0d0d0d0d0d0d0d0d0d0d0d0d0d0d0d0;
  localparam logic [127:0] E = 128'he0e0e0e0e0e0e0e0e0e0e0e0e0e0e0e0;
  logic clk = 1'b0;
  logic rst;
  logic [3:0] blk_count;
  int errors = 0;
  int checks = 0;
  int cnt_exp = 0;
  logic [127:0] d;
  always #5 clk = ~clk;
  round_key_add_stage_if #(.BLOCK_LENGTH(128), .KEY_SEL_W(1), .TAG_WIDTH(4)) bus ();
  round_key_add_stage #(
    .BLOCK_LENGTH(128), .NUM_KEYS(2), .KEY_SEL_W(1), .TAG_WIDTH(4), .ZERO_IDLE(1'b1), .CNT_WIDTH(4)
  ) u_dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .blk_count(blk_count)
  );
  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  initial begin
    rst = 1'b1;
    bus.key_wr_en = 1'b0;
    bus.key_wr_sel = '0;
    bus.key_wr_data = '0;
    bus.in_valid = 1'b0;
    bus.in_data = '0;
    bus.in_key_sel = '0;
    bus.in_tag = '0;
    bus.out_ready = 1'b0;
    step();
    step();
    rst = 1'b0;
    check("rst_out_valid", 128'(bus.out_valid), 128'd0);
    check("rst_in_ready", 128'(bus.in_ready), 128'd1);
    check("rst_out_data", bus.out_data, 128'd0);
    check("rst_out_tag", 128'(bus.out_tag), 128'd0);
    check("rst_blk_count", 128'(blk_count), 128'd0);
    bus.out_ready = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_data = P;
    bus.in_key_sel = 1'b1;
    bus.in_tag = 4'h3;
    step();
    bus.in_valid = 1'b0;
    check("rst_key_cleared", bus.out_data, P);
    step();
    cnt_exp++;
    bus.key_wr_en = 1'b1;
    bus.key_wr_sel = 1'b0;
    bus.key_wr_data = K;
    step();
    bus.key_wr_en = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_data = P;
    bus.in_key_sel = 1'b0;
    bus.in_tag = 4'h5;
    step();
    bus.in_valid = 1'b0;
    check("fips_valid", 128'(bus.out_valid), 128'd1);
    check("fips_data", bus.out_data, C);
    check("fips_tag", 128'(bus.out_tag), 128'd5);
    step();
    cnt_exp++;
    check("idle_valid", 128'(bus.out_valid), 128'd0);
    check("idle_zero_data", bus.out_data, 128'd0);
    check("idle_zero_tag", 128'(bus.out_tag), 128'd0);
    check("cnt_after_fips", 128'(blk_count), 128'(cnt_exp));
    for (int i = 0; i < 8; i++) begin
      d = P ^ 128'(i * 17);
      bus.in_valid = 1'b1;
      bus.in_data = d;
      bus.in_tag = 4'(i);
      step();
      check("stream_valid", 128'(bus.out_valid), 128'd1);
      check("stream_in_ready", 128'(bus.in_ready), 128'd1);
      check("stream_data", bus.out_data, d ^ K);
      check("stream_tag", 128'(bus.out_tag), 128'(i));
    end
    bus.in_valid = 1'b0;
    step();
    cnt_exp += 8;
    check("stream_drained", 128'(bus.out_valid), 128'd0);
    check("stream_cnt", 128'(blk_count), 128'(cnt_exp));
    bus.out_ready = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_data = A;
    step();
    check("bp_first", bus.out_data, A ^ K);
    check("bp_ready_one", 128'(bus.in_ready), 128'd1);
    bus.in_data = B;
    step();
    check("bp_ready_two", 128'(bus.in_ready), 128'd0);
    check("bp_hold_a", bus.out_data, A ^ K);
    bus.in_data = P;
    step();
    check("bp_still_full", 128'(bus.in_ready), 128'd0);
    check("bp_stable_a", bus.out_data, A ^ K);
    check("bp_stable_valid", 128'(bus.out_valid), 128'd1);
    bus.out_ready = 1'b1;
    step();
    check("bp_out_b", bus.out_data, B ^ K);
    check("bp_ready_back", 128'(bus.in_ready), 128'd1);
    step();
    bus.in_valid = 1'b0;
    check("bp_out_c", bus.out_data, C);
    step();
    cnt_exp += 3;
    check("bp_drained", 128'(bus.out_valid), 128'd0);
    check("bp_cnt", 128'(blk_count), 128'(cnt_exp));
    bus.key_wr_en = 1'b1;
    bus.key_wr_sel = 1'b1;
    bus.key_wr_data = K2;
    bus.in_valid = 1'b1;
    bus.in_data = D;
    bus.in_key_sel = 1'b1;
    step();
    bus.key_wr_en = 1'b0;
    check("rbw_old_key", bus.out_data, D);
    bus.in_data = E;
    step();
    bus.in_valid = 1'b0;
    check("rbw_new_key", bus.out_data, E ^ K2);
    step();
    cnt_exp += 2;
    check("cnt_full", 128'(blk_count), 128'(cnt_exp));
    bus.out_ready = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_key_sel = 1'b0;
    bus.in_data = A;
    step();
    bus.in_data = B;
    step();
    check("pre_rst_two", 128'(bus.in_ready), 128'd0);
    bus.in_valid = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("mid_rst_valid", 128'(bus.out_valid), 128'd0);
    check("mid_rst_data", bus.out_data, 128'd0);
    check("mid_rst_ready", 128'(bus.in_ready), 128'd1);
    check("mid_rst_cnt", 128'(blk_count), 128'd0);
    bus.out_ready = 1'b1;
    step();
    check("mid_rst_discard", 128'(bus.out_valid), 128'd0);
    bus.in_valid = 1'b1;
    bus.in_data = A;
    for (int i = 0; i < 20; i++) step();
    bus.in_valid = 1'b0;
    step();
    check("sat_cnt", 128'(blk_count), 128'hf);
    check("sat_idle_data", bus.out_data, 128'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
